// File: rtl/sar_pkg.sv
// Shared phase encodings and defaults for the SAR track controller.
package sar_pkg;

    localparam int DATA_DEF = 8;
    localparam int CNT_W    = 4;

    // Encodings are visible on StateP, so they are fixed rather than tool-chosen.
    typedef enum logic [1:0] {
        ST_TRACK   = 2'b00,
        ST_SEARCH  = 2'b01,
        ST_RESTART = 2'b10,
        ST_INIT    = 2'b11
    } state_t;

endpackage

// File: rtl/sar_settle_counter.sv
// Per-bit comparator settle timer: load, count down, flag terminal count at zero.
module sar_settle_counter
    import sar_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/sar_track_controller.sv
// SAR binary search followed by +/-1 tracking; all outputs registered.
// Optional macro SAR_TRACK_SLEW_EN: RETRACK same-direction steps force a re-search.
//
// state      | meaning
// ST_INIT    | idle after reset, code held, waiting for Start
// ST_SEARCH  | binary search MSB..LSB, SETTLE+1 cycles per bit
// ST_RESTART | one-cycle gap before a new search
// ST_TRACK   | step code by one on CmpI / CmpD
module sar_track_controller
    import sar_pkg::*;
#(
    parameter int DATA    = DATA_DEF,
    parameter int SETTLE  = 1,
    parameter int RETRACK = 4
) (
    input  logic            ClockT,
    input  logic            ResetN,
    input  logic            Start,
    input  logic            CmpC,
    input  logic            CmpI,
    input  logic            CmpD,
    output logic [1:0]      StateP,
    output logic [DATA-1:0] SAROut,
    output logic            Inc,
    output logic            Dcr,
    output logic            Done,
    output logic            Fault
);

    localparam int BW = (DATA > 1) ? $clog2(DATA) : 1;
    localparam logic [DATA-1:0] CODE_MSB = {1'b1, {(DATA-1){1'b0}}};

    if ((SETTLE < 0) || (SETTLE > 15)) begin : g_bad_settle
        $error("SETTLE out of range 0..15");
    end
    if ((RETRACK < 2) || (RETRACK > 15)) begin : g_bad_retrack
        $error("RETRACK out of range 2..15");
    end

    state_t          state_q, state_d;
    logic [DATA-1:0] code_q, code_d;
    logic [BW-1:0]   bit_q, bit_d, bit_dn;
    logic            inc_q, inc_d;
    logic            dcr_q, dcr_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic            settle_load, settle_en, settle_tc;
    logic            slew_trip;

    assign bit_dn = bit_q - 1'b1;

    sar_settle_counter u_settle (
        .clk      (ClockT),
        .rst_n    (ResetN),
        .load     (settle_load),
        .load_val (CNT_W'(SETTLE)),
        .en       (settle_en),
        .tc       (settle_tc)
    );

`ifdef SAR_TRACK_SLEW_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic             dir_q, dir_d;

    assign slew_trip = (run_q == CNT_W'(RETRACK));

    // Run length of consecutive same-direction steps; dir 1 = up.
    always_comb begin
        run_d = run_q;
        dir_d = dir_q;
        if ((state_q != ST_TRACK) || (state_d != ST_TRACK)) begin
            run_d = '0;
        end else if (inc_d) begin
            run_d = (dir_q && (run_q != '0)) ? run_q + 1'b1 : CNT_W'(1);
            dir_d = 1'b1;
        end else if (dcr_d) begin
            run_d = (!dir_q && (run_q != '0)) ? run_q + 1'b1 : CNT_W'(1);
            dir_d = 1'b0;
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge ClockT) begin
        if (!ResetN) begin
            run_q <= '0;
            dir_q <= 1'b0;
        end else begin
            run_q <= run_d;
            dir_q <= dir_d;
        end
    end
`else
    assign slew_trip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        bit_d       = bit_q;
        inc_d       = 1'b0;
        dcr_d       = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        settle_load = 1'b0;
        settle_en   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (Start) begin
                    state_d     = ST_SEARCH;
                    code_d      = CODE_MSB;
                    bit_d       = BW'(DATA - 1);
                    settle_load = 1'b1;
                end
            end

            ST_RESTART: begin
                state_d     = ST_SEARCH;
                code_d      = CODE_MSB;
                bit_d       = BW'(DATA - 1);
                settle_load = 1'b1;
            end

            ST_SEARCH: begin
                settle_en = 1'b1;
                if (settle_tc) begin
                    // Decide this bit and raise the next trial bit on the same edge.
                    code_d[bit_q] = CmpC;
                    if (bit_q == '0) begin
                        state_d = ST_TRACK;
                        done_d  = 1'b1;
                    end else begin
                        bit_d          = bit_dn;
                        code_d[bit_dn] = 1'b1;
                        settle_load    = 1'b1;
                    end
                end
            end

            ST_TRACK: begin
                if (Start || slew_trip) begin
                    state_d = ST_RESTART;
                end else if (CmpI && CmpD) begin
                    fault_d = 1'b1;
                end else if (CmpI && (code_q != '1)) begin
                    code_d = code_q + 1'b1;
                    inc_d  = 1'b1;
                end else if (CmpD && (code_q != '0)) begin
                    code_d = code_q - 1'b1;
                    dcr_d  = 1'b1;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge ClockT) begin
        if (!ResetN) begin
            state_q <= ST_INIT;
            code_q  <= '0;
            bit_q   <= '0;
            inc_q   <= 1'b0;
            dcr_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            bit_q   <= bit_d;
            inc_q   <= inc_d;
            dcr_q   <= dcr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign StateP = state_q;
    assign SAROut = code_q;
    assign Inc    = inc_q;
    assign Dcr    = dcr_q;
    assign Done   = done_q;
    assign Fault  = fault_q;

endmodule

// File: tb/tb_sar_track_controller.sv
// Directed bench for sar_track_controller: search, tracking, rails, fault, slew and reset.
module tb_sar_track_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cmp_c;
    logic       cmp_i;
    logic       cmp_d;
    logic [7:0] vin;
    logic [1:0] state_p;
    logic [7:0] sar_out;
    logic       inc;
    logic       dcr;
    logic       done;
    logic       fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Ideal comparator: analog input at or above the trial code.
    assign cmp_c = (vin >= sar_out);

    sar_track_controller #(
        .DATA    (8),
        .SETTLE  (1),
        .RETRACK (4)
    ) dut (
        .ClockT (clk),
        .ResetN (rst_n),
        .Start  (start),
        .CmpC   (cmp_c),
        .CmpI   (cmp_i),
        .CmpD   (cmp_d),
        .StateP (state_p),
        .SAROut (sar_out),
        .Inc    (inc),
        .Dcr    (dcr),
        .Done   (done),
        .Fault  (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input logic [7:0] v, input logic hold_start);
        int n;
        vin   = v;
        cmp_i = 1'b0;
        cmp_d = 1'b0;
        if (state_p === 2'b00) begin
            start = 1'b1;
            tick();
            checks++;
            if (state_p !== 2'b10) begin
                errors++;
                $display("FAIL restart_phase: got %b expected 10", state_p);
            end
            if (!hold_start) start = 1'b0;
            tick();
        end else begin
            start = 1'b1;
            tick();
            if (!hold_start) start = 1'b0;
        end
        checks++;
        if (state_p !== 2'b01 || sar_out !== 8'h80) begin
            errors++;
            $display("FAIL search_entry: got state %b code %h expected 01 80", state_p, sar_out);
        end
        n = 1;
        while (state_p === 2'b01 && n < 100) begin
            tick();
            if (state_p === 2'b01) n++;
        end
        start = 1'b0;
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL search_length: got %0d expected 16", n);
        end
        checks++;
        if (sar_out !== v || done !== 1'b1 || state_p !== 2'b00) begin
            errors++;
            $display("FAIL search_result: got code %h done %b state %b expected %h 1 00",
                     sar_out, done, state_p, v);
        end
        tick();
        checks++;
        if (done !== 1'b0 || state_p !== 2'b00 || sar_out !== v) begin
            errors++;
            $display("FAIL done_pulse_width: got done %b state %b code %h expected 0 00 %h",
                     done, state_p, sar_out, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cmp_i = 1'b0;
        cmp_d = 1'b0;
        vin   = 8'h00;
        repeat (3) tick();
        checks++;
        if (state_p !== 2'b11 || sar_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got state %b code %h expected 11 00", state_p, sar_out);
        end
        checks++;
        if ({inc, dcr, done, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 0000", {inc, dcr, done, fault});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_p !== 2'b11 || sar_out !== 8'h00) begin
            errors++;
            $display("FAIL init_idle: got state %b code %h expected 11 00", state_p, sar_out);
        end
    endtask

    task automatic test_search();
        run_search(8'hA5, 1'b0);
        run_search(8'h3C, 1'b1);
    endtask

    task automatic test_track_steps();
        cmp_i = 1'b1;
        tick();
        checks++;
        if (sar_out !== 8'h3D || inc !== 1'b1 || dcr !== 1'b0) begin
            errors++;
            $display("FAIL track_inc: got code %h inc %b dcr %b expected 3d 1 0", sar_out, inc, dcr);
        end
        cmp_i = 1'b0;
        cmp_d = 1'b1;
        tick();
        checks++;
        if (sar_out !== 8'h3C || inc !== 1'b0 || dcr !== 1'b1) begin
            errors++;
            $display("FAIL track_dcr: got code %h inc %b dcr %b expected 3c 0 1", sar_out, inc, dcr);
        end
        cmp_d = 1'b0;
        tick();
        checks++;
        if (sar_out !== 8'h3C || inc !== 1'b0 || dcr !== 1'b0) begin
            errors++;
            $display("FAIL track_hold: got code %h inc %b dcr %b expected 3c 0 0", sar_out, inc, dcr);
        end
    endtask

    task automatic test_fault();
        cmp_i = 1'b1;
        cmp_d = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1 || sar_out !== 8'h3C || inc !== 1'b0 || dcr !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse: got fault %b code %h inc %b dcr %b expected 1 3c 0 0",
                     fault, sar_out, inc, dcr);
        end
        cmp_i = 1'b0;
        cmp_d = 1'b0;
        tick();
        checks++;
        if (fault !== 1'b0 || state_p !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: got fault %b state %b expected 0 00", fault, state_p);
        end
    endtask

    task automatic test_rails();
        run_search(8'hFF, 1'b0);
        cmp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (sar_out !== 8'hFF || inc !== 1'b0) begin
                errors++;
                $display("FAIL top_rail: got code %h inc %b expected ff 0", sar_out, inc);
            end
        end
        cmp_i = 1'b0;
        run_search(8'h00, 1'b0);
        cmp_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (sar_out !== 8'h00 || dcr !== 1'b0) begin
                errors++;
                $display("FAIL bottom_rail: got code %h dcr %b expected 00 0", sar_out, dcr);
            end
        end
        cmp_d = 1'b0;
    endtask

    task automatic test_slew();
        int n;
        run_search(8'h40, 1'b0);
        cmp_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (sar_out !== 8'(8'h40 + i) || inc !== 1'b1 || state_p !== 2'b00) begin
                errors++;
                $display("FAIL slew_inc_%0d: got code %h inc %b state %b expected %h 1 00",
                         i, sar_out, inc, state_p, 8'(8'h40 + i));
            end
        end
`ifdef SAR_TRACK_SLEW_EN
        tick();
        checks++;
        if (state_p !== 2'b10 || inc !== 1'b0 || sar_out !== 8'h44) begin
            errors++;
            $display("FAIL slew_restart: got state %b inc %b code %h expected 10 0 44",
                     state_p, inc, sar_out);
        end
        cmp_i = 1'b0;
        tick();
        checks++;
        if (state_p !== 2'b01 || sar_out !== 8'h80) begin
            errors++;
            $display("FAIL slew_research: got state %b code %h expected 01 80", state_p, sar_out);
        end
        n = 0;
        while (state_p !== 2'b00 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sar_out !== 8'h40 || done !== 1'b1) begin
            errors++;
            $display("FAIL slew_result: got code %h done %b expected 40 1", sar_out, done);
        end
`else
        n = 0;
        for (int i = 5; i <= 8; i++) begin
            tick();
            checks++;
            if (sar_out !== 8'(8'h40 + i) || inc !== 1'b1 || state_p !== 2'b00) begin
                errors++;
                $display("FAIL continuous_inc_%0d: got code %h inc %b state %b expected %h 1 00",
                         i, sar_out, inc, state_p, 8'(8'h40 + i));
            end
        end
        cmp_i = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid_search();
        int bad;
        vin   = 8'hA5;
        cmp_i = 1'b0;
        cmp_d = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (6) tick();
        checks++;
        if (state_p !== 2'b01 || sar_out !== 8'hB0) begin
            errors++;
            $display("FAIL mid_search_trial: got state %b code %h expected 01 b0", state_p, sar_out);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (state_p !== 2'b11 || sar_out !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_search_reset: got state %b code %h done %b expected 11 00 0",
                     state_p, sar_out, done);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (done !== 1'b0 || state_p !== 2'b11) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_search();
        test_track_steps();
        test_fault();
        test_rails();
        test_slew();
        test_reset_mid_search();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_track_controller.md
SAR_TRACK_CONTROLLER -- requirements
Module: sar_track_controller

Interface
REQ-001 Parameter DATA, default 8: width of the conversion code.
REQ-002 Parameter SETTLE, default 1: comparator settle cycles per trial bit (range 0..15).
REQ-003 Parameter RETRACK, default 4: consecutive same-direction track steps that force a re-search (range 2..15).
REQ-004 ClockT  input  1  single clock; all state updates on rising edge.
REQ-005 ResetN  input  1  reset, synchronous, active-low.
REQ-006 Start  input  1  level-sampled request to begin or restart a binary search.
REQ-007 CmpC  input  1  comparator result for the current trial code; 1 = analog input at or above code.
REQ-008 CmpI  input  1  comparator against the increment threshold; 1 = input above the current code band.
REQ-009 CmpD  input  1  comparator against the decrement threshold; 1 = input below the current code band.
REQ-010 StateP  output  2  phase: 11 INIT, 01 SEARCH, 10 RESTART, 00 TRACK.
REQ-011 SAROut  output  DATA  current code, trial code during SEARCH.
REQ-012 Inc, Dcr  output  1 each  one-cycle pulses marking a +1 / -1 code step in TRACK.
REQ-013 Done  output  1  one-cycle pulse when SEARCH completes.
REQ-014 Fault  output  1  one-cycle pulse when CmpI and CmpD are both 1 in TRACK.

Function
REQ-015 All outputs SHALL be registered; no combinational path from input to output.
REQ-016 INIT SHALL hold SAROut and wait; Start=1 SHALL move to SEARCH on the next edge.
REQ-017 SEARCH SHALL resolve bits MSB to LSB; each bit SHALL take SETTLE+1 cycles: the trial bit is set on the first cycle, and on the last cycle CmpC is sampled and the bit is kept (CmpC=1) or cleared.
REQ-018 SEARCH SHALL start from code 0 with only the MSB set and SHALL last exactly DATA*(SETTLE+1) cycles.
REQ-019 After the LSB decision the block SHALL enter TRACK and pulse Done in the same cycle that StateP first reads 00.
REQ-020 In TRACK, CmpI=1, CmpD=0 and SAROut not all-ones SHALL increment SAROut and pulse Inc.
REQ-021 In TRACK, CmpD=1, CmpI=0 and SAROut not zero SHALL decrement SAROut and pulse Dcr.
REQ-022 At the rails, the step SHALL be suppressed: no wrap and no Inc/Dcr pulse.
REQ-023 CmpI=CmpD=1 in TRACK SHALL hold SAROut, suppress Inc/Dcr and pulse Fault.
REQ-024 Start=1 in TRACK SHALL go to RESTART (10) for one cycle, then SEARCH; Start SHALL be ignored during SEARCH and RESTART.
REQ-025 Inc and Dcr SHALL never be high in the same cycle and SHALL be 0 outside TRACK.

Reset
REQ-026 ResetN=0 at a clock edge SHALL force StateP=11, SAROut=0, Inc=Dcr=Done=Fault=0, clear the settle, bit and run counters, and abort any search.
REQ-027 The first edge with ResetN=1 SHALL behave as INIT.

Configuration
REQ-028 Macro SAR_TRACK_SLEW_EN: when defined, RETRACK consecutive Inc pulses (or RETRACK consecutive Dcr pulses) SHALL cause RESTART then SEARCH. A hold cycle or a direction change SHALL clear the run counter.
REQ-029 Without SAR_TRACK_SLEW_EN, TRACK SHALL step indefinitely, the run counter SHALL be absent, and RETRACK SHALL be unused.

Structure
REQ-030 Shared package sar_pkg SHALL hold the StateP encodings (ST_INIT, ST_SEARCH, ST_RESTART, ST_TRACK) and the DATA default.
REQ-031 The SETTLE countdown SHALL be one sub-module, sar_settle_counter (load, count, terminal flag); the FSM and code register stay in the top.

Verification
REQ-032 DATA=8, SETTLE=1, comparator model at 0xA5, Start pulse -> SEARCH for 16 cycles, then SAROut=0xA5, Done for 1 cycle, StateP=00.
REQ-033 In TRACK at 0xFF with CmpI=1 -> SAROut stays 0xFF and no Inc; at 0x00 with CmpD=1 -> SAROut stays 0x00 and no Dcr.
REQ-034 In TRACK, CmpI=CmpD=1 for 1 cycle -> Fault pulse, SAROut unchanged, Inc=Dcr=0.
REQ-035 SAR_TRACK_SLEW_EN on, RETRACK=4, CmpI held at 1 from 0x40 -> Inc on 4 cycles (to 0x44), then StateP 10 then 01; with the macro off -> continuous Inc.
REQ-036 ResetN=0 for 1 cycle in the middle of SEARCH (bit 4) -> next cycle StateP=11, SAROut=0, Done never pulses.
